// File: rtl/wbu_writeback.sv
// Writeback unit: retires EXU results and LSU load responses as one registered RF write plus
// a commit pulse. Define WBU_FWD_EN to add the writeback-to-decode forwarding ports.
module wbu_writeback #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_rd_wen,
  input  logic               in_is_load,
  input  logic [2:0]         in_ld_funct3,
  input  logic [1:0]         in_addr_lo,
  input  logic [XLEN-1:0]    in_alu_res,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_data,
  input  logic               mem_rsp_err,
`ifdef WBU_FWD_EN
  input  logic [RADDR_W-1:0] fwd_raddr1,
  input  logic [RADDR_W-1:0] fwd_raddr2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [XLEN-1:0]    fwd_data1,
  output logic [XLEN-1:0]    fwd_data2,
`endif
  output logic               rf_wen,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               commit_valid,
  output logic               commit_err
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [0:0]         state_q, state_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               rd_wen_q, rd_wen_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         addr_lo_q, addr_lo_d;

  logic               rf_wen_q, rf_wen_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               commit_valid_q, commit_valid_d;
  logic               commit_err_q, commit_err_d;

  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    ld_data;
  logic               ld_fmt_fault;
  logic               ld_fault;

  assign in_ready = (state_q == IDLE);

  // Byte/half lanes are picked from the latched address; format faults are decided here too.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    ld_data      = '0;
    ld_fmt_fault = 1'b0;
    ld_half      = addr_lo_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rsp_data[7:0];
      2'd1:    ld_byte = mem_rsp_data[15:8];
      2'd2:    ld_byte = mem_rsp_data[23:16];
      default: ld_byte = mem_rsp_data[31:24];
    endcase
    case (funct3_q)
      F3_LB:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data      = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_fmt_fault = addr_lo_q[0];
      end
      F3_LHU: begin
        ld_data      = {{(XLEN-16){1'b0}}, ld_half};
        ld_fmt_fault = addr_lo_q[0];
      end
      F3_LW: begin
        ld_data      = mem_rsp_data;
        ld_fmt_fault = (addr_lo_q != 2'd0);
      end
      default: ld_fmt_fault = 1'b1;
    endcase
  end

  assign ld_fault = ld_fmt_fault | mem_rsp_err;

  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    rd_wen_d       = rd_wen_q;
    funct3_d       = funct3_q;
    addr_lo_d      = addr_lo_q;
    rf_wen_d       = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    commit_valid_d = 1'b0;
    commit_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            rd_d      = in_rd;
            rd_wen_d  = in_rd_wen;
            funct3_d  = in_ld_funct3;
            addr_lo_d = in_addr_lo;
            state_d   = WAIT_MEM;
          end else begin
            commit_valid_d = 1'b1;
            if (in_rd_wen && (in_rd != '0)) begin
              rf_wen_d   = 1'b1;
              rf_waddr_d = in_rd;
              rf_wdata_d = in_alu_res;
            end
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          state_d        = IDLE;
          commit_valid_d = 1'b1;
          commit_err_d   = ld_fault;
          if (rd_wen_q && (rd_q != '0) && !ld_fault) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_q           <= '0;
      rd_wen_q       <= 1'b0;
      funct3_q       <= '0;
      addr_lo_q      <= '0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      rd_q           <= rd_d;
      rd_wen_q       <= rd_wen_d;
      funct3_q       <= funct3_d;
      addr_lo_q      <= addr_lo_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_err_q   <= commit_err_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_err   = commit_err_q;

`ifdef WBU_FWD_EN
  // Decode reads the value being written this cycle instead of the stale RF entry.
  assign fwd_hit1  = rf_wen_q && (rf_waddr_q == fwd_raddr1) && (fwd_raddr1 != '0);
  assign fwd_hit2  = rf_wen_q && (rf_waddr_q == fwd_raddr2) && (fwd_raddr2 != '0);
  assign fwd_data1 = rf_wdata_q;
  assign fwd_data2 = rf_wdata_q;
`endif

endmodule

// File: tb/tb_wbu_writeback.sv
// Self-checking bench for wbu_writeback: directed literal cases, then randomized traffic
// compared every cycle against a transaction-level model.
module tb_wbu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic        commit_err;
`ifdef WBU_FWD_EN
  logic [4:0]  fwd_raddr1;
  logic [4:0]  fwd_raddr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  wbu_writeback #(.XLEN(32), .RADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_rd_wen     (in_rd_wen),
    .in_is_load    (in_is_load),
    .in_ld_funct3  (in_ld_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_res    (in_alu_res),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
`ifdef WBU_FWD_EN
    .fwd_raddr1    (fwd_raddr1),
    .fwd_raddr2    (fwd_raddr2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
`endif
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .commit_valid  (commit_valid),
    .commit_err    (commit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected outputs for the current cycle plus the load waiting for its response.
  bit          exp_ready = 1'b1;
  bit          exp_cv    = 1'b0;
  bit          exp_err   = 1'b0;
  bit          exp_wen   = 1'b0;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [4:0]  pl_rd;
  bit          pl_wen;
  logic [2:0]  pl_f3;
  logic [1:0]  pl_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                   input logic [31:0] w, input bit err,
                                   output bit fault, output logic [31:0] val);
    int unsigned sh, b, h;
    sh    = 8 * int'(lo);
    b     = (w >> sh) & 32'hFF;
    h     = (w >> sh) & 32'hFFFF;
    fault = err;
    val   = '0;
    case (f3)
      3'b000: val = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b100: val = b;
      3'b001: begin val = (h >= 32768) ? (h | 32'hFFFF_0000) : h; fault = fault || lo[0]; end
      3'b101: begin val = h; fault = fault || lo[0]; end
      3'b010: begin val = w; fault = fault || (lo != 2'd0); end
      default: fault = 1'b1;
    endcase
  endfunction

  function automatic void mdl_reset();
    exp_ready = 1'b1;
    exp_cv    = 1'b0;
    exp_err   = 1'b0;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endfunction

  // Applies the transaction rules to whatever the inputs held at this clock edge.
  function automatic void mdl_edge();
    bit          acc, rsp, fault;
    logic [31:0] val;
    if (!rst_n) begin
      mdl_reset();
      return;
    end
    acc     = in_valid && exp_ready;
    rsp     = mem_rsp_valid && !exp_ready;
    exp_cv  = 1'b0;
    exp_err = 1'b0;
    exp_wen = 1'b0;
    if (acc && in_is_load) begin
      pl_rd = in_rd; pl_wen = in_rd_wen; pl_f3 = in_ld_funct3; pl_lo = in_addr_lo;
      exp_ready = 1'b0;
    end else if (acc) begin
      exp_cv = 1'b1;
      if (in_rd_wen && in_rd != 0) begin
        exp_wen = 1'b1; exp_waddr = in_rd; exp_wdata = in_alu_res;
      end
    end else if (rsp) begin
      ref_load(pl_f3, pl_lo, mem_rsp_data, mem_rsp_err, fault, val);
      exp_cv    = 1'b1;
      exp_err   = fault;
      exp_ready = 1'b1;
      if (pl_wen && pl_rd != 0 && !fault) begin
        exp_wen = 1'b1; exp_waddr = pl_rd; exp_wdata = val;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    mdl_edge();
    @(negedge clk);
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    #1;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("commit_valid", 64'(commit_valid), 64'(exp_cv));
    check("commit_err", 64'(commit_err), 64'(exp_err));
    check("rf_wen", 64'(rf_wen), 64'(exp_wen));
    check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
    check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
`ifdef WBU_FWD_EN
    check("fwd_hit1", 64'(fwd_hit1), 64'(exp_wen && exp_waddr == fwd_raddr1 && fwd_raddr1 != 0));
    check("fwd_hit2", 64'(fwd_hit2), 64'(exp_wen && exp_waddr == fwd_raddr2 && fwd_raddr2 != 0));
    check("fwd_data1", 64'(fwd_data1), 64'(exp_wdata));
    check("fwd_data2", 64'(fwd_data2), 64'(exp_wdata));
`endif
  end

  task automatic drive_idle();
    in_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input bit wen, input logic [31:0] res);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_rd_wen = wen; in_alu_res = res;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_rd_wen = 1'b1;
    in_ld_funct3 = f3; in_addr_lo = lo;
  endtask

  // Issues a load, holds in_valid while waiting, returns in the cycle its commit is visible.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] data, input bit err, input int nwait);
    drive_load(rd, f3, lo);
    tick();
    for (int i = 0; i < nwait; i++) begin
      check("in_ready_wait", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = data; mem_rsp_err = err;
    tick();
    drive_idle();
  endtask

  task automatic expect_out(input string name, input bit cv, input bit err, input bit wen,
                            input logic [4:0] waddr, input logic [31:0] wdata);
    check({name, ".commit_valid"}, 64'(commit_valid), 64'(cv));
    check({name, ".commit_err"}, 64'(commit_err), 64'(err));
    check({name, ".rf_wen"}, 64'(rf_wen), 64'(wen));
    check({name, ".rf_waddr"}, 64'(rf_waddr), 64'(waddr));
    check({name, ".rf_wdata"}, 64'(rf_wdata), 64'(wdata));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [5];
    int wait_cnt;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst_n = 1'b0;
    in_is_load = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_ld_funct3 = '0;
    in_addr_lo = '0; in_alu_res = '0; mem_rsp_data = '0;
    drive_idle();
`ifdef WBU_FWD_EN
    fwd_raddr1 = '0; fwd_raddr2 = '0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    #2;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    expect_out("reset", 0, 0, 0, 5'd0, 32'h0);

    // ALU write, then the pulse must drop and data hold.
    drive_alu(5'd5, 1'b1, 32'h1234_5678);
    tick();
    drive_idle();
    #2;
    expect_out("alu", 1, 0, 1, 5'd5, 32'h1234_5678);
    tick();
    #2;
    expect_out("alu_after", 0, 0, 0, 5'd5, 32'h1234_5678);

    drive_alu(5'd0, 1'b1, 32'hFFFF_FFFF);
    tick();
    drive_idle();
    #2;
    expect_out("rd0", 1, 0, 0, 5'd5, 32'h1234_5678);

    do_load(5'd7, 3'b000, 2'd3, 32'h80AB_CDEF, 1'b0, 3);
    #2;
    expect_out("lb", 1, 0, 1, 5'd7, 32'hFFFF_FF80);
    do_load(5'd7, 3'b100, 2'd3, 32'h80AB_CDEF, 1'b0, 2);
    #2;
    expect_out("lbu", 1, 0, 1, 5'd7, 32'h0000_0080);
    do_load(5'd7, 3'b101, 2'd2, 32'h80AB_CDEF, 1'b0, 1);
    #2;
    expect_out("lhu", 1, 0, 1, 5'd7, 32'h0000_80AB);

    do_load(5'd8, 3'b010, 2'd1, 32'hDEAD_BEEF, 1'b0, 2);
    #2;
    expect_out("lw_misalign", 1, 1, 0, 5'd7, 32'h0000_80AB);
    do_load(5'd8, 3'b010, 2'd0, 32'hDEAD_BEEF, 1'b1, 0);
    #2;
    expect_out("bus_err", 1, 1, 0, 5'd7, 32'h0000_80AB);

    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
    tick();
    drive_idle();
    #2;
    expect_out("spurious_rsp", 0, 0, 0, 5'd7, 32'h0000_80AB);
    check("spurious_rsp.in_ready", 64'(in_ready), 64'd1);

    // Reset while a load is outstanding; a late response must be dropped.
    drive_load(5'd9, 3'b010, 2'd0);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    mdl_reset();
    #1;
    expect_out("rst_mid", 0, 0, 0, 5'd0, 32'h0);
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_F00D;
    tick();
    drive_idle();
    #2;
    expect_out("late_rsp", 0, 0, 0, 5'd0, 32'h0);
    check("late_rsp.in_ready", 64'(in_ready), 64'd1);

    // Three back-to-back ALU ops: a write every cycle.
    drive_alu(5'd3, 1'b1, 32'hAAAA_0001);
    tick();
    drive_alu(5'd4, 1'b1, 32'hAAAA_0002);
`ifdef WBU_FWD_EN
    fwd_raddr1 = 5'd3; fwd_raddr2 = 5'd0;
`endif
    #2;
    expect_out("b2b_1", 1, 0, 1, 5'd3, 32'hAAAA_0001);
`ifdef WBU_FWD_EN
    check("fwd_b2b_1.hit1", 64'(fwd_hit1), 64'd1);
    check("fwd_b2b_1.data1", 64'(fwd_data1), 64'hAAAA_0001);
    check("fwd_b2b_1.hit2", 64'(fwd_hit2), 64'd0);
`endif
    tick();
    drive_alu(5'd6, 1'b1, 32'hAAAA_0003);
`ifdef WBU_FWD_EN
    fwd_raddr1 = 5'd4;
`endif
    #2;
    expect_out("b2b_2", 1, 0, 1, 5'd4, 32'hAAAA_0002);
`ifdef WBU_FWD_EN
    check("fwd_b2b_2.hit1", 64'(fwd_hit1), 64'd1);
`endif
    tick();
    drive_idle();
`ifdef WBU_FWD_EN
    fwd_raddr1 = 5'd6;
`endif
    #2;
    expect_out("b2b_3", 1, 0, 1, 5'd6, 32'hAAAA_0003);
`ifdef WBU_FWD_EN
    check("fwd_b2b_3.data1", 64'(fwd_data1), 64'hAAAA_0003);
`endif
    tick();
    #2;
    expect_out("b2b_idle", 0, 0, 0, 5'd6, 32'hAAAA_0003);
`ifdef WBU_FWD_EN
    check("fwd_idle.hit1", 64'(fwd_hit1), 64'd0);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    wait_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      if (exp_ready) begin
        wait_cnt = 0;
        if ($urandom_range(0, 9) < 7) begin
          int k;
          in_valid     = 1'b1;
          in_is_load   = 1'($urandom_range(0, 1));
          in_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          in_rd_wen    = ($urandom_range(0, 4) != 0);
          k            = int'($urandom_range(0, 11));
          in_ld_funct3 = (k < 10) ? f3_tab[k % 5] : 3'($urandom_range(0, 7));
          in_addr_lo   = 2'($urandom_range(0, 3));
          in_alu_res   = $urandom;
        end else begin
          in_valid = 1'b0;
        end
        mem_rsp_valid = ($urandom_range(0, 9) == 0);
        mem_rsp_err   = 1'($urandom_range(0, 1));
      end else begin
        wait_cnt++;
        in_valid      = 1'($urandom_range(0, 1));
        mem_rsp_valid = (wait_cnt > 15) || ($urandom_range(0, 3) == 0);
        mem_rsp_err   = ($urandom_range(0, 7) == 0);
      end
      mem_rsp_data = $urandom;
`ifdef WBU_FWD_EN
      fwd_raddr1 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : exp_waddr;
      fwd_raddr2 = ($urandom_range(0, 1) == 0) ? 5'd0 : exp_waddr;
`endif
      tick();
    end
    drive_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
